// File: rtl/tick_pkg.sv
// Shared BCD types and constants for the tick-driven BCD counter.
package tick_pkg;

    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned NUM_DIGITS_DEF = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t BCD_MAX  = 4'd9;
    localparam digit_t BCD_ZERO = 4'd0;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: next value plus carry/borrow-out for an increment or decrement.
// cin means "this digit must move this cycle" (digit 0: the step itself,
// higher digits: carry/borrow out of the digit below).
module bcd_digit
    import tick_pkg::*;
(
    input  digit_t digit,
    input  logic   inc,
    input  logic   dec,
    input  logic   cin,
    output digit_t digit_nxt,
    output logic   cout
);

    // BCD step of a single digit; anything at or above 9 wraps on increment
    always_comb begin
        digit_nxt = digit;
        cout      = 1'b0;
        if (cin && inc) begin
            if (digit >= BCD_MAX) begin
                digit_nxt = BCD_ZERO;
                cout      = 1'b1;
            end else begin
                digit_nxt = digit + 4'd1;
            end
        end else if (cin && dec) begin
            if (digit == BCD_ZERO) begin
                digit_nxt = BCD_MAX;
                cout      = 1'b1;
            end else begin
                digit_nxt = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/tick_bcd_counter.sv
// Up/down BCD counter advanced by rising edges of a slow tick input.
// Optional macro TICK_SYNC_EN adds a two-flop synchronizer in front of the
// edge detector for a tick_in that is asynchronous to clkin.
module tick_bcd_counter
    import tick_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
    parameter bit          WRAP       = 1'b1
) (
    input  logic                          clkin,
    input  logic                          rst_n,
    input  logic                          tick_in,
    input  logic                          en,
    input  logic                          up,
    input  logic                          clr,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count,
    output logic                          rollover,
    output logic                          at_max,
    output logic                          at_zero
);

    localparam int unsigned CNT_W = DIGIT_W * NUM_DIGITS;

    logic             tick_src;
    logic             tick_q;
    logic             step_c;
    logic             inc_c;
    logic             dec_c;
    logic             wrap_c;
    logic [CNT_W-1:0] count_nxt;
    logic [NUM_DIGITS:0] carry;

`ifdef TICK_SYNC_EN
    logic tick_s1;
    logic tick_s2;

    // Two-flop synchronizer; resets high so a held-high tick is not an edge
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            tick_s1 <= 1'b1;
            tick_s2 <= 1'b1;
        end else begin
            tick_s1 <= tick_in;
            tick_s2 <= tick_s1;
        end
    end

    assign tick_src = tick_s2;
`else
    assign tick_src = tick_in;
`endif

    // Edge-detect history; resets high to suppress a step at reset release
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b1;
        end else begin
            tick_q <= tick_src;
        end
    end

    assign step_c = tick_src & ~tick_q;
    assign inc_c  = step_c & en & up;
    assign dec_c  = step_c & en & ~up;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .digit     (count[DIGIT_W*i +: DIGIT_W]),
            .inc       (inc_c),
            .dec       (dec_c),
            .cin       (carry[i]),
            .digit_nxt (count_nxt[DIGIT_W*i +: DIGIT_W]),
            .cout      (carry[i+1])
        );
    end

    // Carry/borrow out of the top digit means the whole counter wrapped
    assign wrap_c = carry[NUM_DIGITS];

    // Count register: clear beats step, wrap either rolls or saturates
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            rollover <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            rollover <= 1'b0;
        end else if (wrap_c) begin
            if (WRAP) begin
                count    <= count_nxt;
                rollover <= 1'b1;
            end else begin
                rollover <= 1'b0;
            end
        end else begin
            count    <= count_nxt;
            rollover <= 1'b0;
        end
    end

    assign at_max  = (count == {NUM_DIGITS{BCD_MAX}});
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed bench for tick_bcd_counter: one wrapping and one saturating instance
// driven by the same stimulus.
module tb_tick_bcd_counter;

`ifdef TICK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        tick_in;
    logic        en;
    logic        up;
    logic        clr;
    logic [15:0] count_w;
    logic        roll_w;
    logic        max_w;
    logic        zero_w;
    logic [15:0] count_s;
    logic        roll_s;
    logic        max_s;
    logic        zero_s;

    int ncmp = 0;
    int nerr = 0;

    tick_bcd_counter #(.NUM_DIGITS(4), .WRAP(1'b1)) dut_w (
        .clkin    (clk),
        .rst_n    (rst_n),
        .tick_in  (tick_in),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .count    (count_w),
        .rollover (roll_w),
        .at_max   (max_w),
        .at_zero  (zero_w)
    );

    tick_bcd_counter #(.NUM_DIGITS(4), .WRAP(1'b0)) dut_s (
        .clkin    (clk),
        .rst_n    (rst_n),
        .tick_in  (tick_in),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .count    (count_s),
        .rollover (roll_s),
        .at_max   (max_s),
        .at_zero  (zero_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rise/fall of tick_in per two cycles, then let the pipeline drain
    task automatic fast_ticks(input int n);
        repeat (n) begin
            @(negedge clk) tick_in = 1'b1;
            @(negedge clk) tick_in = 0;
        end
        repeat (LAT + 1) @(negedge clk);
    endtask

    // One tick with cycle-exact latency and rollover pulse checks
    task automatic step_chk(input string tag,
                            input logic [15:0] pw, input logic [15:0] ew,
                            input logic [15:0] ps, input logic [15:0] es,
                            input logic rw);
        @(negedge clk) tick_in = 1'b1;
        repeat (LAT - 1) begin
            @(posedge clk) #1;
            check({tag, " early_w"}, 32'(count_w), 32'(pw));
            check({tag, " early_s"}, 32'(count_s), 32'(ps));
        end
        @(posedge clk) #1;
        check({tag, " count_w"}, 32'(count_w), 32'(ew));
        check({tag, " count_s"}, 32'(count_s), 32'(es));
        check({tag, " roll_w"}, 32'(roll_w), 32'(rw));
        check({tag, " roll_s"}, 32'(roll_s), 32'(0));
        @(posedge clk) #1;
        check({tag, " roll_w_drop"}, 32'(roll_w), 32'(0));
        check({tag, " held_w"}, 32'(count_w), 32'(ew));
        tick_in = 1'b0;
        repeat (LAT) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        tick_in = 1'b1;
        en      = 1'b1;
        up      = 1'b1;
        clr     = 1'b0;

        // Reset state before any clock edge
        #3;
        check("rst count", 32'(count_w), 32'(0));
        check("rst roll", 32'(roll_w), 32'(0));
        check("rst at_zero", 32'(zero_w), 32'(1));
        check("rst at_max", 32'(max_w), 32'(0));

        // Release with tick_in held high: no spurious step
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk) #1;
            check("hold_high count", 32'(count_w), 32'(0));
            check("hold_high roll", 32'(roll_w), 32'(0));
        end
        tick_in = 1'b0;
        repeat (LAT + 1) @(negedge clk);

        // Twelve single steps, each landing exactly LAT cycles after the edge
        begin
            logic [15:0] seq [0:12];
            seq = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
                    16'h0007, 16'h0008, 16'h0009, 16'h0010, 16'h0011, 16'h0012};
            for (int i = 0; i < 12; i++)
                step_chk("up12", seq[i], seq[i+1], seq[i], seq[i+1], 1'b0);
        end
        check("up12 final", 32'(count_w), 32'(16'h0012));

        // Preload to 9999 and wrap / saturate
        do_clear();
        check("clr", 32'(count_w), 32'(0));
        fast_ticks(9999);
        check("pre count_w", 32'(count_w), 32'(16'h9999));
        check("pre count_s", 32'(count_s), 32'(16'h9999));
        check("pre at_max", 32'(max_w), 32'(1));
        step_chk("wrap_up", 16'h9999, 16'h0000, 16'h9999, 16'h9999, 1'b1);
        check("wrap at_zero", 32'(zero_w), 32'(1));
        check("sat at_max", 32'(max_s), 32'(1));

        // Down from 0000 wraps to 9999; saturating copy just decrements
        up = 1'b0;
        step_chk("wrap_dn", 16'h0000, 16'h9999, 16'h9999, 16'h9998, 1'b1);

        // Borrow across two digits
        do_clear();
        up = 1'b1;
        fast_ticks(100);
        check("pre100", 32'(count_w), 32'(16'h0100));
        up = 1'b0;
        step_chk("borrow", 16'h0100, 16'h0099, 16'h0100, 16'h0099, 1'b0);

        // Saturating copy holds at 0000 on a down step
        do_clear();
        step_chk("sat_dn", 16'h0000, 16'h9999, 16'h0000, 16'h0000, 1'b1);

        // Clear coincident with a step wins and the step is not replayed
        do_clear();
        up = 1'b1;
        fast_ticks(57);
        check("pre57", 32'(count_w), 32'(16'h0057));
        @(negedge clk) tick_in = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        clr = 1'b1;
        @(posedge clk) #1;
        check("clr_vs_step", 32'(count_w), 32'(0));
        @(negedge clk) clr = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check("clr_no_defer", 32'(count_w), 32'(0));
        tick_in = 1'b0;
        repeat (LAT + 1) @(negedge clk);

        // Steps with en low are dropped, not deferred
        en = 1'b0;
        fast_ticks(3);
        check("en_off", 32'(count_w), 32'(0));
        en = 1'b1;
        step_chk("en_on", 16'h0000, 16'h0001, 16'h0000, 16'h0001, 1'b0);

        // Direction change takes effect on the very next step
        step_chk("dir_up", 16'h0001, 16'h0002, 16'h0001, 16'h0002, 1'b0);
        up = 1'b0;
        step_chk("dir_dn", 16'h0002, 16'h0001, 16'h0002, 16'h0001, 1'b0);

        // Mid-run asynchronous reset abandons an in-flight step
        up = 1'b1;
        fast_ticks(4);
        check("pre_rst", 32'(count_w), 32'(16'h0005));
        @(negedge clk) tick_in = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", 32'(count_w), 32'(0));
        check("async_rst_s", 32'(count_s), 32'(0));
        @(negedge clk) rst_n = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        check("post_rst", 32'(count_w), 32'(0));
        check("post_rst roll", 32'(roll_w), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/tick_bcd_counter.md
TICK_BCD_COUNTER -- requirements
Module: tick_bcd_counter

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning the number of BCD digits counted (legal 1..8).
REQ-002 The block SHALL have parameter WRAP, default 1, meaning 1 = wrap at limits and 0 = saturate at limits.
REQ-003 The block SHALL have port clkin, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port tick_in, input, 1 bit: slow divided-clock input from the upstream clock divider; each rising edge is one count event.
REQ-006 The block SHALL have port en, input, 1 bit: count enable.
REQ-007 The block SHALL have port up, input, 1 bit: direction, 1 = increment and 0 = decrement.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear.
REQ-009 The block SHALL have port count, output, 4*NUM_DIGITS bits: packed BCD value, digit 0 in bits [3:0].
REQ-010 The block SHALL have port rollover, output, 1 bit: one-cycle pulse on wrap.
REQ-011 The block SHALL have ports at_max and at_zero, output, 1 bit each: combinational flags for count = all 9s and count = 0.

Function
REQ-012 Edge detect SHALL register tick_in into tick_q each cycle, with step = tick_in AND NOT tick_q.
REQ-013 Latency: when step=1 in cycle N, count SHALL hold the updated value from cycle N+1; a tick_in held high SHALL produce exactly one step.
REQ-014 Priority: clr > step; clr=1 SHALL load 0 regardless of en, up or step, and a coincident step SHALL be discarded.
REQ-015 step with en=0 SHALL be ignored; it SHALL NOT be deferred.
REQ-016 Increment SHALL be BCD: a digit at 9 goes to 0 and carries to the next digit; other digits add 1; no digit ever exceeds 9.
REQ-017 Decrement SHALL be BCD: a digit at 0 goes to 9 and borrows from the next digit.
REQ-018 Up at all 9s SHALL load 0 and pulse rollover for one cycle when WRAP=1; when WRAP=0 it SHALL hold and rollover stays 0.
REQ-019 Down at 0 SHALL load all 9s and pulse rollover for one cycle when WRAP=1; when WRAP=0 it SHALL hold.
REQ-020 rollover SHALL be registered and asserted in the same cycle the wrapped count first appears.
REQ-021 A direction change between steps SHALL take effect on the next step, with no extra latency.

Reset
REQ-022 rst_n=0 SHALL asynchronously force count=0, rollover=0, and all edge-detect/sync flops=1.
REQ-023 With reset flops at 1, tick_in high at reset release SHALL produce no spurious step.
REQ-024 Reset asserted mid-count SHALL abandon the in-flight step, and count SHALL restart from 0.

Configuration
REQ-025 Macro TICK_SYNC_EN, if defined, SHALL insert a two-flop synchronizer ahead of tick_q, making step latency 3 cycles from the tick_in rise to the count change.
REQ-026 Without TICK_SYNC_EN, tick_in SHALL feed tick_q directly, giving 1-cycle latency; tick_in is then required to be synchronous to clkin.

Structure
REQ-027 A shared package tick_pkg SHALL hold the BCD digit typedef (4-bit), the constants BCD_MAX=4'd9 and BCD_ZERO=4'd0, and the default NUM_DIGITS.
REQ-028 Sub-module bcd_digit SHALL implement one digit (inputs: digit, inc, dec, carry/borrow-in; outputs: next digit, carry/borrow-out), instantiated NUM_DIGITS times by generate.

Verification
REQ-029 Reset with tick_in=1, release, hold tick_in=1 for 10 cycles -> count stays 0000 and rollover stays 0.
REQ-030 en=1, up=1, 12 tick_in rising edges -> count=0012; each update appears 1 cycle after the edge (3 cycles with TICK_SYNC_EN).
REQ-031 Preload to 9999 via 9999 steps, WRAP=1, one more step -> count=0000 and rollover high for exactly 1 cycle; with WRAP=0 -> count holds 9999 and rollover=0.
REQ-032 count=0000, up=0, one step -> 9999 with rollover pulse (WRAP=1); at count=0100, one down step -> 0099 (borrow across two digits).
REQ-033 count=0057, clr=1 and a tick edge in the same cycle -> count=0000 next cycle, with no increment to 0001.
REQ-034 en=0 during 3 edges, then en=1 and 1 edge -> count advances by exactly 1; assert rst_n low mid-run -> count=0000 immediately, without waiting for a clock edge.
